reg_preload_loader: RTL and testbench
=====================================

// Module: reg_preload_loader
// PURPOSE
//  Writer-side counterpart to the bench's register-dump path: streams initial register values into
//  the regfile write port before the processor runs. Sits between processor and regfile write port;
//  holds the CPU in reset while loading, then hands the write port back to the CPU transparently.
//  Lets directed tests start from a known register image without preamble instructions in imem.
// PARAMETERS
//  NUM_REGS  32  regfile depth
//  ADDR_W    5   regfile index width (log2 NUM_REGS)
//  DATA_W    32  register data width
//  SKIP_R0   1   1: r0 is hardwired zero, load r1..r(NUM_REGS-1); 0: load r0..r(NUM_REGS-1)
// PORTS
//  clock        in   1       system clock, all state on rising edge
//  reset        in   1       asynchronous, active-low; clears all state
//  start        in   1       1-cycle pulse, begins a load; honoured only in IDLE
//  in_valid     in   1       load beat valid
//  in_data      in   DATA_W  load beat data
//  in_ready     out  1       loader accepts beat this cycle
//  cpu_we       in   1       processor ctrl_writeEnable
//  cpu_wr_reg   in   ADDR_W  processor ctrl_writeReg
//  cpu_wr_data  in   DATA_W  processor data_writeReg
//  rf_we        out  1       to regfile ctrl_writeEnable
//  rf_wr_reg    out  ADDR_W  to regfile ctrl_writeReg
//  rf_wr_data   out  DATA_W  to regfile data_writeReg
//  cpu_hold     out  1       1 = hold processor in reset
//  busy         out  1       1 in LOAD or FLUSH
//  done         out  1       1 in RUN
//  count        out  6       beats accepted in current/last load
//  err          out  1       sticky: cpu_we seen while cpu_hold=1
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, count=0, err=0, pend=0; outputs in_ready=0, rf_we=0,
//   rf_wr_reg=0, rf_wr_data=0, cpu_hold=1, busy=0, done=0. in_ready drops immediately.
//  States: IDLE -(start)-> LOAD -(last beat accepted)-> FLUSH -> RUN. RUN exits only via reset.
//  IDLE: in_ready=0; in_valid ignored; start outside IDLE ignored.
//  LOAD: in_ready=1. Beat accepted on edge where in_valid&in_ready. Accepted beat n (n=count)
//   registered into pending write: pend=1, idx=n+SKIP_R0, data=in_data; count<=count+1.
//  Pending write: during cycle after accept, rf_we=1, rf_wr_reg=idx, rf_wr_data=data; regfile
//   commits on following edge (latency: accept edge k -> commit edge k+1). pend clears unless a new
//   beat is accepted same edge (back-to-back at 1 beat/cycle, no bubbles required).
//  Last beat: count reaches NUM_REGS-SKIP_R0 on accept -> FLUSH. FLUSH: in_ready=0, drives final
//   pending write, cpu_hold=1. Next edge -> RUN.
//  RUN: cpu_hold=0, done=1, in_ready=0; rf_we/rf_wr_reg/rf_wr_data = cpu_* combinationally (no delay).
//  IDLE/LOAD/FLUSH: cpu_* write is dropped (never reaches regfile); if cpu_we=1 set err (sticky to reset).
//  count width: 6 bits, never exceeds NUM_REGS; no wrap.
//  Reset mid-load: aborts immediately; already-committed regfile writes remain; in-flight pending write
//   is discarded (rf_we forced 0 asynchronously).
// TESTING
//  1 reset, start, 31 beats data=100+i no stalls -> r1..r31=100..130, r0=0, count=31, done 2 edges after last accept.
//  2 in_valid toggled every other cycle -> identical final image; rf_we pulses only after accepted beats.
//  3 in_valid=1 data=0xFFFF in IDLE without start -> in_ready=0, no rf_we, count=0.
//  4 reset low after 10 beats -> in_ready/busy 0 same cycle, count=0; r1..r10 keep values, r11..r31 unchanged.
//  5 RUN: cpu_we=1 reg 5 data 0xDEAD -> rf_we=1,rf_wr_reg=5 same cycle; cpu_we=1 during LOAD -> no write, err=1.
//  6 SKIP_R0=0: 32 beats data=i*3 -> first beat targets r0, r31=93, count=32.

Source files
------------

// File: rtl/reg_preload_loader.sv
// Streams an initial register image into the regfile write port while holding the CPU in reset,
// then hands the write port back to the CPU as a transparent pass-through.
module reg_preload_loader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter bit SKIP_R0  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_wr_reg,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [5:0]        count,
    output logic              err
);

    localparam int NUM_BEATS = NUM_REGS - int'(SKIP_R0);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

    state_t            state, state_nxt;
    logic              pend;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              accept;
    logic              last_beat;

    assign accept    = (state == LOAD) && in_valid;
    assign last_beat = accept && (count == 6'(NUM_BEATS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Outside RUN the write port carries only the loader's pending write; cpu writes are dropped.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        cpu_hold   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        rf_we      = pend;
        rf_wr_reg  = idx;
        rf_wr_data = data;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_beat) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                cpu_hold   = 1'b0;
                done       = 1'b1;
                rf_we      = cpu_we;
                rf_wr_reg  = cpu_wr_reg;
                rf_wr_data = cpu_wr_data;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-deep write buffer: an accepted beat is presented to the regfile during the next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend  <= 1'b0;
            idx   <= '0;
            data  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            pend <= accept;
            if (accept) begin
                idx   <= ADDR_W'(count) + ADDR_W'(SKIP_R0);
                data  <= in_data;
                count <= count + 6'd1;
            end
            if (cpu_we && (state != RUN)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_preload_loader.sv
// Randomized bench for reg_preload_loader: a beat-count based model checked every cycle, a bench-side
// regfile image, and literal checks for the directed scenarios.
module tb_reg_preload_loader;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = NR - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic cpu_we = 1'b0;
    logic [AW-1:0] cpu_wr_reg = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic in_ready, rf_we, cpu_hold, busy, done, err;
    logic [AW-1:0] rf_wr_reg;
    logic [DW-1:0] rf_wr_data;
    logic [5:0] count;

    logic start0 = 1'b0, in_valid0 = 1'b0;
    logic [DW-1:0] in_data0 = '0;
    logic cpu_we0 = 1'b0;
    logic [AW-1:0] cpu_wr_reg0 = '0;
    logic [DW-1:0] cpu_wr_data0 = '0;
    logic in_ready0, rf_we0, cpu_hold0, busy0, done0, err0;
    logic [AW-1:0] rf_wr_reg0;
    logic [DW-1:0] rf_wr_data0;
    logic [5:0] count0;

    reg_preload_loader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_R0(1'b1)) u_dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cpu_we(cpu_we), .cpu_wr_reg(cpu_wr_reg), .cpu_wr_data(cpu_wr_data),
        .rf_we(rf_we), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .count(count), .err(err));

    reg_preload_loader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_R0(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .start(start0), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .cpu_we(cpu_we0), .cpu_wr_reg(cpu_wr_reg0), .cpu_wr_data(cpu_wr_data0),
        .rf_we(rf_we0), .rf_wr_reg(rf_wr_reg0), .rf_wr_data(rf_wr_data0), .cpu_hold(cpu_hold0),
        .busy(busy0), .done(done0), .count(count0), .err(err0));

    always #5 clock = ~clock;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bench-side regfile: write port sampled mid-cycle, committed on the rising edge.
    logic [DW-1:0] rf [NR];
    logic [DW-1:0] rf0 [NR];
    logic lw_en = 1'b0, lw_en0 = 1'b0;
    logic [AW-1:0] lw_reg = '0, lw_reg0 = '0;
    logic [DW-1:0] lw_data = '0, lw_data0 = '0;
    logic fill_req = 1'b0;
    logic [DW-1:0] fill_val = '0;

    always @(negedge clock) begin
        lw_en = rf_we;   lw_reg = rf_wr_reg;   lw_data = rf_wr_data;
        lw_en0 = rf_we0; lw_reg0 = rf_wr_reg0; lw_data0 = rf_wr_data0;
    end

    always @(posedge clock) begin
        if (fill_req) begin
            for (int i = 0; i < NR; i++) begin
                rf[i]  <= fill_val;
                rf0[i] <= fill_val;
            end
        end else begin
            if (lw_en && reset)  rf[lw_reg]   <= lw_data;
            if (lw_en0 && reset) rf0[lw_reg0] <= lw_data0;
        end
    end

    // Model: everything derives from whether a load was started, how many beats were taken,
    // and how many edges have passed since the image became complete.
    bit m_started = 1'b0;
    int m_beats = 0;
    int m_age = 0;
    bit m_err = 1'b0;
    bit m_pw = 1'b0;
    int m_pw_idx = 0;
    logic [DW-1:0] m_pw_data = '0;
    bit m_acc;

    function automatic bit e_in_ready();
        return m_started && (m_beats < NB);
    endfunction
    function automatic bit e_done();
        return m_age >= 2;
    endfunction
    function automatic bit e_busy();
        return e_in_ready() || (m_age == 1);
    endfunction

    always @(negedge reset) begin
        m_started = 1'b0; m_beats = 0; m_age = 0; m_err = 1'b0; m_pw = 1'b0;
    end

    always @(posedge clock) begin
        if (reset) begin
            m_acc = e_in_ready() && in_valid;
            if (cpu_we && !e_done()) m_err = 1'b1;
            if (!m_started && start) m_started = 1'b1;
            m_pw = m_acc;
            if (m_acc) begin
                m_pw_idx  = m_beats + 1;
                m_pw_data = in_data;
                m_beats++;
            end
            if (m_age > 0 && m_age < 3) m_age++;
            else if (m_age == 0 && m_beats == NB) m_age = 1;
        end
    end

    always @(negedge clock) begin
        bit exp_we;
        exp_we = e_done() ? cpu_we : m_pw;
        chk("in_ready", in_ready, e_in_ready());
        chk("busy", busy, e_busy());
        chk("done", done, e_done());
        chk("cpu_hold", cpu_hold, !e_done());
        chk("count", count, m_beats);
        chk("err", err, m_err);
        chk("rf_we", rf_we, exp_we);
        if (exp_we) begin
            chk("rf_wr_reg", rf_wr_reg, e_done() ? cpu_wr_reg : AW'(m_pw_idx));
            chk("rf_wr_data", rf_wr_data, e_done() ? cpu_wr_data : m_pw_data);
        end
    end

    logic [DW-1:0] img [NR];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; cpu_we = 1'b0; start0 = 1'b0; in_valid0 = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic fill(input logic [DW-1:0] v);
        fill_val = v; fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    // mode 0: continuous, 1: every other cycle, 2: random gaps
    task automatic load(input int n, input int mode, input bit rnd_cpu);
        int sent;
        int guard;
        bit rdy;
        sent = 0; guard = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (sent < n && guard < 2000) begin
            rdy = e_in_ready();
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
            in_data = img[sent];
            if (rnd_cpu) begin
                cpu_we = (guard == 0) || ($urandom_range(0, 3) == 0);
                cpu_wr_reg = AW'($urandom);
                cpu_wr_data = $urandom;
            end
            tick();
            if (rdy && in_valid) sent++;
            guard++;
        end
        in_valid = 1'b0;
        cpu_we = 1'b0;
        chk("load_beats", sent, n);
    endtask

    task automatic run_cpu(input int n);
        repeat (n) begin
            cpu_we = 1'($urandom_range(0, 1));
            cpu_wr_reg = AW'($urandom);
            cpu_wr_data = $urandom;
            tick();
        end
        cpu_we = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick();
        chk("rst_in_ready", in_ready, 0); chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wr_reg", rf_wr_reg, 0); chk("rst_rf_wr_data", rf_wr_data, 0);
        chk("rst_cpu_hold", cpu_hold, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_count", count, 0); chk("rst_err", err, 0);
        reset = 1'b1;

        // beats in IDLE without start are ignored
        in_valid = 1'b1; in_data = 32'hFFFF;
        repeat (4) begin
            tick();
            chk("idle_in_ready", in_ready, 0); chk("idle_rf_we", rf_we, 0); chk("idle_count", count, 0);
        end
        in_valid = 1'b0;

        // continuous load of 100+i
        fill('0);
        for (int i = 0; i < NR; i++) img[i] = 100 + i;
        load(NB, 0, 1'b0);
        chk("flush_done", done, 0); chk("flush_busy", busy, 1);
        chk("flush_rf_we", rf_we, 1); chk("flush_reg", rf_wr_reg, 31); chk("flush_data", rf_wr_data, 130);
        tick();
        chk("run_done", done, 1); chk("run_hold", cpu_hold, 0); chk("run_count", count, 31);
        tick();
        chk("img1_r0", rf[0], 0);
        for (int k = 1; k < NR; k++) chk("img1", rf[k], 99 + k);

        // cpu pass-through in RUN
        chk("run_err", err, 0);
        cpu_we = 1'b1; cpu_wr_reg = 5'd5; cpu_wr_data = 32'hDEAD;
        #1;
        chk("pass_we", rf_we, 1); chk("pass_reg", rf_wr_reg, 5); chk("pass_data", rf_wr_data, 32'hDEAD);
        tick();
        run_cpu(20);

        // every-other-cycle valid gives the same image
        do_reset();
        fill('0);
        load(NB, 1, 1'b0);
        tick(); tick();
        chk("img2_count", count, 31); chk("img2_done", done, 1);
        for (int k = 1; k < NR; k++) chk("img2", rf[k], 99 + k);

        // random data, random gaps, cpu writes during load flag err
        for (int r = 0; r < 3; r++) begin
            do_reset();
            fill('0);
            for (int i = 0; i < NR; i++) img[i] = $urandom;
            load(NB, 2, 1'b1);
            tick(); tick();
            chk("rnd_err", err, 1);
            for (int k = 1; k < NR; k++) chk("img_rnd", rf[k], img[k-1]);
            run_cpu(30);
        end

        // reset mid-load
        do_reset();
        fill(32'h5A5A_0000);
        for (int i = 0; i < NR; i++) img[i] = 500 + i;
        load(10, 0, 1'b0);
        tick();
        in_valid = 1'b1; in_data = img[10];
        tick();
        in_valid = 1'b0;
        chk("inflight_we", rf_we, 1);
        reset = 1'b0;
        #1;
        chk("abort_we", rf_we, 0); chk("abort_in_ready", in_ready, 0);
        chk("abort_busy", busy, 0); chk("abort_count", count, 0);
        tick(); tick();
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) chk("abort_kept", rf[k], 499 + k);
        for (int k = 11; k < NR; k++) chk("abort_untouched", rf[k], 32'h5A5A_0000);

        // SKIP_R0=0 instance loads r0..r31
        fill(32'hFFFF_FFFF);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < NR; i++) begin
            chk("s0_in_ready", in_ready0, 1);
            in_valid0 = 1'b1; in_data0 = i * 3;
            tick();
            if (i == 0) begin
                chk("s0_first_we", rf_we0, 1); chk("s0_first_reg", rf_wr_reg0, 0); chk("s0_first_data", rf_wr_data0, 0);
            end
        end
        in_valid0 = 1'b0;
        chk("s0_count", count0, 32); chk("s0_busy", busy0, 1); chk("s0_done_early", done0, 0);
        tick();
        chk("s0_done", done0, 1); chk("s0_hold", cpu_hold0, 0); chk("s0_err", err0, 0);
        chk("s0_r0", rf0[0], 0); chk("s0_r15", rf0[15], 45); chk("s0_r31", rf0[31], 93);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
